// File: rtl/truth_table_driver.sv
// Sweeps every input combination of a small combinational DUT, holds each for HOLD
// cycles, captures dut_y once per combination and scores it against EXPECT.
module truth_table_driver #(
  parameter int                  N_IN   = 2,
  parameter int                  HOLD   = 10,
  parameter int                  SAMPLE = 1,
  parameter logic [2**N_IN-1:0]  EXPECT = 4'b0111
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] fail_idx,
  output logic            sample_valid,
  output logic            sample_data
);

  localparam int              HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [HW-1:0]   SAMPLE_AT = HW'(SAMPLE);
  localparam logic [N_IN-1:0] IDX_LAST  = '1;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t          state_reg;
  logic [N_IN-1:0] idx_reg;
  logic [HW-1:0]   hold_cnt_reg;

  logic capture;
  logic mismatch;
  logic hold_end;

  assign capture  = (state_reg == DRIVE) && (hold_cnt_reg == SAMPLE_AT);
  assign mismatch = capture && (dut_y != EXPECT[idx_reg]);
  assign hold_end = (state_reg == DRIVE) && (hold_cnt_reg == HOLD_LAST);
  assign stim     = idx_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      hold_cnt_reg <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_cnt      <= '0;
      fail_idx     <= '0;
      sample_valid <= 1'b0;
      sample_data  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg    <= DRIVE;
            idx_reg      <= '0;
            hold_cnt_reg <= '0;
            err_cnt      <= '0;
            fail_idx     <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            busy         <= 1'b1;
          end
        end
        DRIVE: begin
          if (capture) begin
            sample_data  <= dut_y;
            sample_valid <= 1'b1;
            if (mismatch) begin
              err_cnt <= err_cnt + (N_IN+1)'(1);
              if (err_cnt == '0)
                fail_idx <= idx_reg;
            end
          end
          if (hold_end) begin
            hold_cnt_reg <= '0;
            if (idx_reg != IDX_LAST) begin
              idx_reg <= idx_reg + N_IN'(1);
            end else begin
              // A capture landing on the final edge must still count towards pass.
              state_reg <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              pass      <= (err_cnt == '0) && !mismatch;
            end
          end else begin
            hold_cnt_reg <= hold_cnt_reg + HW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_driver.sv
// Scoreboard bench: the driver pushes expected captures and sweep summaries,
// a negedge monitor pops and compares them as the drivers present results.
module tb_truth_table_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [3:0] y_tab = 4'b0111;

  logic [1:0] stim0;
  logic       dut_y0, busy0, done0, pass0, sv0, sd0;
  logic [2:0] err0;
  logic [1:0] fidx0;

  logic [0:0] stim1;
  logic       dut_y1, busy1, done1, pass1, sv1, sd1;
  logic [1:0] err1;
  logic [0:0] fidx1;

  always #5 clk = ~clk;

  assign dut_y0 = y_tab[stim0];
  assign dut_y1 = ~stim1[0];

  truth_table_driver u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stim(stim0), .dut_y(dut_y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_idx(fidx0),
    .sample_valid(sv0), .sample_data(sd0)
  );

  truth_table_driver #(.N_IN(1), .HOLD(3), .SAMPLE(2), .EXPECT(2'b01)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stim(stim1), .dut_y(dut_y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_idx(fidx1),
    .sample_valid(sv1), .sample_data(sd1)
  );

  typedef struct { logic data; logic [1:0] idx; } samp_t;
  typedef struct { logic pass; logic [2:0] err; logic [1:0] fidx; int lat; } sum_t;

  samp_t sq0[$];
  sum_t  mq0[$];
  logic  sq1[$];
  sum_t  mq1[$];

  int n_cmp = 0, n_fail = 0;
  int tmo_cnt = 0, tmo_seen = 0;
  int bcnt0 = 0, bcnt1 = 0;
  logic final_chk = 1'b0, final_done = 1'b0;
  logic rst_seen = 1'b0;
  logic busy0_q = 1'b0, done0_q = 1'b0, done1_q = 1'b0;

  always @(posedge clk) rst_seen <= !rst_n;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic flag_fail(string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  always @(negedge clk) begin
    samp_t s;
    sum_t  m;
    logic  d;
    if (rst_seen) begin
      check("rst_stim", 32'(stim0), 32'(0));
      check("rst_busy", 32'(busy0), 32'(0));
      check("rst_done", 32'(done0), 32'(0));
      check("rst_err", 32'(err0), 32'(0));
      check("rst_pass", 32'(pass0), 32'(0));
      check("rst_sv", 32'(sv0), 32'(0));
      if (mq0.size() > 0) void'(mq0.pop_front());
      sq0.delete();
      bcnt0 = 0;
      $display("reset: stim=%0d busy=%0b done=%0b err=%0d", stim0, busy0, done0, err0);
    end else begin
      if (sv0) begin
        if (sq0.size() == 0) flag_fail("sample0_unexpected");
        else begin
          s = sq0.pop_front();
          $display("dut0 sample: idx=%0d y=%0b (want idx=%0d y=%0b)", stim0, sd0, s.idx, s.data);
          check("sample0_data", 32'(sd0), 32'(s.data));
          check("sample0_idx", 32'(stim0), 32'(s.idx));
        end
      end
      if (busy0 && !busy0_q && mq0.size() == 0) flag_fail("start0_unexpected");
      if (busy0) bcnt0++;
      if (done0 && !done0_q) begin
        if (mq0.size() == 0) flag_fail("done0_unexpected");
        else begin
          m = mq0.pop_front();
          $display("dut0 done: pass=%0b err=%0d fidx=%0d lat=%0d", pass0, err0, fidx0, bcnt0);
          check("done0_pass", 32'(pass0), 32'(m.pass));
          check("done0_err", 32'(err0), 32'(m.err));
          if (m.err != 0) check("done0_fidx", 32'(fidx0), 32'(m.fidx));
          check("done0_latency", 32'(bcnt0), 32'(m.lat));
          check("done0_stim_last", 32'(stim0), 32'(3));
        end
        bcnt0 = 0;
      end
      if (sv1) begin
        if (sq1.size() == 0) flag_fail("sample1_unexpected");
        else begin
          d = sq1.pop_front();
          $display("dut1 sample: y=%0b (want %0b)", sd1, d);
          check("sample1_data", 32'(sd1), 32'(d));
        end
      end
      if (busy1) bcnt1++;
      if (done1 && !done1_q) begin
        if (mq1.size() == 0) flag_fail("done1_unexpected");
        else begin
          m = mq1.pop_front();
          $display("dut1 done: pass=%0b err=%0d lat=%0d", pass1, err1, bcnt1);
          check("done1_pass", 32'(pass1), 32'(m.pass));
          check("done1_err", 32'(err1), 32'(m.err));
          check("done1_latency", 32'(bcnt1), 32'(m.lat));
        end
        bcnt1 = 0;
      end
    end
    if (tmo_cnt != tmo_seen) begin
      tmo_seen = tmo_cnt;
      flag_fail("done_timeout");
    end
    if (final_chk && !final_done) begin
      final_done = 1'b1;
      check("left_samples0", 32'(sq0.size()), 32'(0));
      check("left_summaries0", 32'(mq0.size()), 32'(0));
      check("left_samples1", 32'(sq1.size()), 32'(0));
      check("left_summaries1", 32'(mq1.size()), 32'(0));
    end
    busy0_q = busy0;
    done0_q = done0;
    done1_q = done1;
  end

  task automatic push0(logic [3:0] ytab, logic p, logic [2:0] e, logic [1:0] f);
    samp_t s;
    sum_t  m;
    for (int i = 0; i < 4; i++) begin
      s.data = ytab[i];
      s.idx  = 2'(i);
      sq0.push_back(s);
    end
    m.pass = p; m.err = e; m.fidx = f; m.lat = 40;
    mq0.push_back(m);
  endtask

  task automatic pulse0();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
  endtask

  task automatic wait_done0(int budget);
    int k = 0;
    while (!done0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!done0) tmo_cnt++;
  endtask

  initial begin
    sum_t m;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // NAND DUT matches the default table
    y_tab = 4'b0111; push0(4'b0111, 1'b1, 3'd0, 2'd0);
    pulse0(); wait_done0(60);

    // AND DUT mismatches everywhere
    y_tab = 4'b1000; push0(4'b1000, 1'b0, 3'd4, 2'd0);
    pulse0(); wait_done0(60);

    // NAND with stuck-high output at index 3
    y_tab = 4'b1111; push0(4'b1111, 1'b0, 3'd1, 2'd3);
    pulse0(); wait_done0(60);

    // re-pulse mid sweep is ignored; err_cnt cleared from the previous run
    y_tab = 4'b0111; push0(4'b0111, 1'b1, 3'd0, 2'd0);
    pulse0();
    repeat (14) @(negedge clk);
    start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    wait_done0(60);

    // start on the very edge done rises must not restart
    push0(4'b0111, 1'b1, 3'd0, 2'd0);
    pulse0();
    repeat (39) @(negedge clk);
    start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    repeat (5) @(negedge clk);

    // a later start restarts normally
    push0(4'b0111, 1'b1, 3'd0, 2'd0);
    pulse0(); wait_done0(60);

    // reset at edge 22 of a sweep abandons it
    push0(4'b0111, 1'b1, 3'd0, 2'd0);
    pulse0();
    repeat (21) @(negedge clk);
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // single-input inverter configuration
    sq1.push_back(1'b1); sq1.push_back(1'b0);
    m.pass = 1'b1; m.err = 3'd0; m.fidx = 2'd0; m.lat = 6;
    mq1.push_back(m);
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int k = 0; k < 20 && !done1; k++) @(negedge clk);
    if (!done1) tmo_cnt++;

    repeat (3) @(negedge clk);
    final_chk = 1'b1;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
